adiabatic_pclk_seq: RTL and testbench
=====================================

# adiabatic_pclk_seq

Four-phase power-clock sequencer for the adiabatic datapath. It generates stepwise-charged trapezoidal level codes for the four power-clock phases. Each code drives a phase's step-charger switch bank, whose enables are buffered to the array by the fo64 irreversible inverter stage directly downstream. It guarantees that no phase ever starts, stops or is truncated mid-ramp during start-up or drain, so charge recovery is never broken except by reset.

## Interface
- STEPS, default 4: charge steps per ramp; also the cycles per quarter-period. Legal values are 2..15.
- LW, default $clog2(STEPS+1): width of each phase level code.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  request; high = keep the power clocks cycling, low = drain and stop.
- lvl  output  4*LW  phase k level code at lvl[k*LW +: LW]; 0 = vss rail, STEPS = full vdd.
- sync  output  1  one-cycle pulse on the first cycle of each period while in RUN.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on return to IDLE after a drain.

## Operation
- State machine states: IDLE, RUN, DRAIN.
- Counters:
  - q, the quarter index, 2 bits.
  - s, the step within the quarter, 0..STEPS-1.
  - s wraps to 0 after STEPS-1 and increments q; q wraps 3 -> 0.
  - Period length = 4*STEPS cycles.
- Each phase k has a relative quarter r = (q - k) mod 4 and an active bit.
- Level of phase k when active:
  - r=0 (rise): s+1.
  - r=1 (hold): STEPS.
  - r=2 (fall): STEPS-1-s.
  - r=3 (idle): 0.
- Level of an inactive phase = 0.
- Activation:
  - In RUN, phase k becomes active at the cycle where r=0 and s=0.
  - In DRAIN, a phase reaching r=0, s=0 stays inactive.
  - An active phase clears its bit on the cycle it reaches r=3, s=0, in both RUN and DRAIN.
  - An active phase therefore always completes rise, hold and fall in full.
- Transitions:
  - IDLE -> RUN: on run=1. At that edge q=0, s=0, phase 0 activates and lvl0=1.
  - RUN -> DRAIN: on run=0.
  - DRAIN -> RUN: on run=1. Counters continue without reset; phases activate at their next r=0, s=0.
  - DRAIN -> IDLE: on the edge where the last active phase clears (or immediately if none are active). At that edge counters go to 0, all lvl are 0, and done=1 for one cycle.
- sync = 1 on cycles with q=0, s=0 while state is RUN; this includes the first RUN cycle.
- In IDLE, counters are held at 0 and run=0 keeps all outputs 0.

## Timing
- All outputs are registered and update on the same edge as q and s.
- There is no combinational path from run to any output.
- Latency: run is sampled high at edge E; lvl0=1 and busy=1 are visible after E.
  - Phase k first leaves 0 at E + k*STEPS cycles.
- Reset values: lvl=0 (all phases), sync=0, busy=0, done=0, state=IDLE, q=0, s=0, all active bits=0.
- Reset mid-operation forces all of the above on the next edge and overrides run. This is abrupt (non-adiabatic) and is the only way a ramp may be truncated.
- Simultaneous events:
  - run falling on a cycle where phase k is at r=0, s=0: the state is still RUN at that edge, so phase k activates and completes.
  - run rising on the DRAIN -> IDLE edge: DRAIN -> IDLE wins; RUN starts on the next edge with run still high.
- Adjacent phases overlap so that exactly one phase is rising, one holding, one falling and one idle in steady state.

## Test plan
- Reset: assert rst for 2 cycles with run=1 -> lvl=0, busy=0, sync=0, done=0. After rst drops, the first run edge gives lvl0=1 and sync=1.
- Steady state (STEPS=4): run held high -> lvl0 sequence from start is 1,2,3,4, 4,4,4,4, 3,2,1,0, 0,0,0,0 and repeats. lvl1 is the same sequence delayed by 4 cycles. sync fires every 16 cycles.
- Drain mid-period: run drops at cycle n=5 (q=1, s=1) -> phases 2 and 3 never leave 0. Phase 1 completes its full trapezoid. busy falls and done pulses at n=16. All lvl remain 0 afterwards.
- Re-run during drain: run low at n=5 and high again at n=9 -> state is RUN, phase 2 stays 0 (its r=0, s=0 fell in DRAIN at n=8), phase 3 activates at n=12, and done never pulses.
- Reset mid-ramp: rst at n=2 -> next edge gives all lvl=0 and busy=0, with no done pulse.
- STEPS=2 (LW=2) sweep: period is 8 cycles and lvl0 = 1,2,2,2,1,0,0,0. Check all four phases and the r=2 arithmetic STEPS-1-s.

Source files
------------

// File: rtl/adiabatic_pclk_seq_if.sv
// Handshake bundle between the power-clock sequencer and its requester:
// the run request in, the four packed phase level codes and status flags out.
interface adiabatic_pclk_seq_if #(
   parameter int LW = 3
);
   logic          run;
   logic [4*LW-1:0] lvl;
   logic          sync;
   logic          busy;
   logic          done;

   modport master (output run, input lvl, input sync, input busy, input done);
   modport slave  (input run, output lvl, output sync, output busy, output done);
endinterface

// File: rtl/adiabatic_pclk_seq.sv
// Four-phase trapezoidal power-clock sequencer: stepwise rise, hold, fall, idle
// per phase, with start-up and drain only ever at whole-trapezoid boundaries.
//
// state | meaning
// IDLE  | counters parked at 0, all phases at vss, waiting for run
// RUN   | counters cycling, phases start at their quarter boundary
// DRAIN | counters cycling, no new phase starts, active ones finish
module adiabatic_pclk_seq #(
   parameter int STEPS = 4,
   parameter int LW    = $clog2(STEPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   adiabatic_pclk_seq_if.slave  pc
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [LW-1:0] SMAX  = LW'(STEPS - 1);
   localparam logic [LW-1:0] SFULL = LW'(STEPS);

   state_t          state, state_n;
   logic [1:0]      q, q_n;
   logic [LW-1:0]   s, s_n;
   logic [3:0]      act, act_n, kept;
   logic [4*LW-1:0] lvl_n;
   logic            sync_n, done_n;

   always_comb begin
      state_n = state;
      q_n     = q;
      s_n     = s;
      kept    = act;
      act_n   = act;
      lvl_n   = '0;
      sync_n  = 1'b0;
      done_n  = 1'b0;

      if (state != IDLE) begin
         if (s == SMAX) begin
            s_n = '0;
            q_n = q + 2'd1;
         end else begin
            s_n = s + LW'(1);
         end
      end

      // A phase retires as it enters its idle quarter, after a complete fall.
      for (int k = 0; k < 4; k++) begin
         if (s_n == '0 && 2'(q_n - 2'(k)) == 2'd3) kept[k] = 1'b0;
      end

      case (state)
         IDLE:    if (pc.run) state_n = RUN;
         RUN:     if (!pc.run) state_n = DRAIN;
         DRAIN: begin
            if (kept == 4'b0000) state_n = IDLE;
            else if (pc.run)     state_n = RUN;
         end
         default: state_n = IDLE;
      endcase

      act_n = kept;
      if (state_n == RUN) begin
         for (int k = 0; k < 4; k++) begin
            if (s_n == '0 && q_n == 2'(k)) act_n[k] = 1'b1;
         end
      end

      if (state == DRAIN && state_n == IDLE) begin
         q_n    = '0;
         s_n    = '0;
         act_n  = '0;
         done_n = 1'b1;
      end

      sync_n = (state_n == RUN) && (q_n == 2'd0) && (s_n == '0);

      for (int k = 0; k < 4; k++) begin
         if (act_n[k]) begin
            case (2'(q_n - 2'(k)))
               2'd0:    lvl_n[k*LW +: LW] = s_n + LW'(1);
               2'd1:    lvl_n[k*LW +: LW] = SFULL;
               2'd2:    lvl_n[k*LW +: LW] = SMAX - s_n;
               default: lvl_n[k*LW +: LW] = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         q       <= '0;
         s       <= '0;
         act     <= '0;
         pc.lvl  <= '0;
         pc.sync <= 1'b0;
         pc.busy <= 1'b0;
         pc.done <= 1'b0;
      end else begin
         state   <= state_n;
         q       <= q_n;
         s       <= s_n;
         act     <= act_n;
         pc.lvl  <= lvl_n;
         pc.sync <= sync_n;
         pc.busy <= (state_n != IDLE);
         pc.done <= done_n;
      end
   end

endmodule

// File: tb/tb_adiabatic_pclk_seq.sv
// Scoreboard bench for adiabatic_pclk_seq: STEPS=4 and STEPS=2 instances,
// directed run/rst patterns, expected trapezoids from start-cycle tables.
module tb_adiabatic_pclk_seq;

   localparam int BIG = 100000;

   typedef struct packed {
      logic [15:0] n;
      logic [15:0] lv;
      logic        sync;
      logic        busy;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst4, rst2;
   int   checks = 0;
   int   failures = 0;
   string scn = "none";
   exp_t q4[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   adiabatic_pclk_seq_if #(.LW(3)) if4 ();
   adiabatic_pclk_seq_if #(.LW(2)) if2 ();

   adiabatic_pclk_seq #(.STEPS(4)) dut4 (.clk(clk), .rst(rst4), .pc(if4));
   adiabatic_pclk_seq #(.STEPS(2)) dut2 (.clk(clk), .rst(rst2), .pc(if2));

   function automatic int trap(input int i, input int S);
      if (i < S)       return i + 1;
      else if (i < 2*S) return S;
      else if (i < 3*S) return 3*S - 1 - i;
      else             return 0;
   endfunction

   function automatic bit run_at(input int c, input int lo, input int hi);
      return !(c >= lo && c < hi);
   endfunction

   // allow bit k*4+m enables the trapezoid of phase k starting at k*S + m*4*S
   function automatic exp_t model(input int S, input int n_in, input int lo_in,
                                  input int hi_in, input int idle_in, input bit restart,
                                  input logic [15:0] allow_in, input int rst_at);
      exp_t e;
      int n, lo, hi, idle, st;
      logic [15:0] allow;
      bit runp;
      e = '0;
      e.n = 16'(n_in);
      n = n_in; lo = lo_in; hi = hi_in; idle = idle_in; allow = allow_in;
      if (rst_at >= 0 && n > rst_at) return e;
      if (n > idle) begin
         if (!restart) return e;
         n = n - idle - 1;
         lo = BIG; hi = BIG; idle = BIG; allow = 16'hFFFF;
      end
      if (n == idle) begin
         e.done = 1'b1;
         return e;
      end
      e.busy = 1'b1;
      runp = (n == 0) || run_at(n - 1, lo, hi);
      e.sync = runp && (n % (4*S) == 0);
      for (int k = 0; k < 4; k++) begin
         for (int m = 0; m < 4; m++) begin
            if (allow[k*4+m]) begin
               st = k*S + m*4*S;
               if (n >= st) e.lv[k*4 +: 4] = e.lv[k*4 +: 4] + 4'(trap(n - st, S));
            end
         end
      end
      return e;
   endfunction

   task automatic drive(input int d, input logic r, input logic rs);
      if (d == 0) begin if4.run = r; rst4 = rs; end
      else        begin if2.run = r; rst2 = rs; end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q4.push_back(e);
      else        q2.push_back(e);
   endtask

   task automatic do_reset(input int d, input logic rv);
      exp_t z;
      z = '0;
      for (int i = 0; i < 2; i++) begin
         drive(d, rv, 1'b1);
         tick();
         push(d, z);
      end
      drive(d, 1'b0, 1'b0);
   endtask

   // cycle n is the output after the n-th edge counted from the run-accepting edge;
   // run/rst values named for cycle c are driven during c and sampled at its end
   task automatic scenario(input string name, input int d, input int S, input int ncyc,
                           input int lo, input int hi, input int idle_at, input bit restart,
                           input logic [15:0] allow, input int rst_at);
      logic rv, rsv;
      int c;
      scn = name;
      drive(d, 1'b1, 1'b0);
      tick();
      push(d, model(S, 0, lo, hi, idle_at, restart, allow, rst_at));
      for (int n = 1; n < ncyc; n++) begin
         c = n - 1;
         rsv = (c == rst_at);
         rv  = run_at(c, lo, hi) && !(rst_at >= 0 && c > rst_at);
         drive(d, rv, rsv);
         tick();
         push(d, model(S, n, lo, hi, idle_at, restart, allow, rst_at));
      end
      drive(d, 1'b0, 1'b0);
   endtask

   task automatic compare(input int d, input exp_t e, input exp_t a);
      checks++;
      if (a.lv !== e.lv || a.sync !== e.sync || a.busy !== e.busy || a.done !== e.done) begin
         failures++;
         $display("FAIL %s steps=%0d n=%0d got lvl=%h sync=%b busy=%b done=%b expected lvl=%h sync=%b busy=%b done=%b",
                  scn, (d == 0) ? 4 : 2, e.n, a.lv, a.sync, a.busy, a.done,
                  e.lv, e.sync, e.busy, e.done);
      end
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         a = '0;
         for (int k = 0; k < 4; k++) a.lv[k*4 +: 4] = 4'(if4.lvl[k*3 +: 3]);
         a.sync = if4.sync; a.busy = if4.busy; a.done = if4.done;
         compare(0, e, a);
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         a = '0;
         for (int k = 0; k < 4; k++) a.lv[k*4 +: 4] = 4'(if2.lvl[k*2 +: 2]);
         a.sync = if2.sync; a.busy = if2.busy; a.done = if2.done;
         compare(1, e, a);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b0, 1'b1);

      scn = "reset4";
      do_reset(0, 1'b1);
      scenario("steady4",     0, 4, 48, BIG, BIG, BIG, 1'b0, 16'hFFFF, -1);
      do_reset(0, 1'b0);
      scenario("drain4",      0, 4, 24, 5,   BIG, 16,  1'b0, 16'h0011, -1);
      do_reset(0, 1'b0);
      scenario("rerun4",      0, 4, 40, 5,   9,   BIG, 1'b0, 16'hFEFF, -1);
      do_reset(0, 1'b0);
      scenario("fall_at_r0",  0, 4, 26, 8,   BIG, 20,  1'b0, 16'h0111, -1);
      do_reset(0, 1'b0);
      scenario("rise_on_idle",0, 4, 24, 5,   15,  16,  1'b1, 16'h0011, -1);
      do_reset(0, 1'b0);
      scenario("rst_midramp", 0, 4, 8,  BIG, BIG, BIG, 1'b0, 16'hFFFF, 2);

      scn = "reset2";
      do_reset(1, 1'b1);
      scenario("steady2",     1, 2, 24, BIG, BIG, BIG, 1'b0, 16'hFFFF, -1);
      do_reset(1, 1'b0);
      scenario("drain2",      1, 2, 14, 3,   BIG, 8,   1'b0, 16'h0011, -1);

      for (int i = 0; i < 10 && (q4.size() > 0 || q2.size() > 0); i++) @(posedge clk);
      checks++;
      if (q4.size() > 0 || q2.size() > 0) begin
         failures++;
         $display("FAIL drain_queue got pending=%0d expected pending=0", q4.size() + q2.size());
      end
      #10;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
